// File: rtl/keystream_xor.sv
// keystream_xor: packs serial keystream bits LSB-first into a 2-byte FIFO and XORs it onto a byte stream
module keystream_xor (
  input  logic        clk,
  input  logic        rst,
  input  logic        ks_bit,
  input  logic        ks_valid,
  output logic        ks_req,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] byte_cnt,
  output logic        ks_overflow
);
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]  ks_count_q, ks_count_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        ks_overflow_q, ks_overflow_d;
  logic        bit_acc, push, pop, wr_one;
  always_comb begin
    ks_req        = (ks_count_q < 2'd2) && !rst;
    din_ready     = (ks_count_q != 2'd0) && (!dout_valid_q || dout_ready);
    bit_acc       = ks_valid && ks_req;
    push          = bit_acc && (bitcnt_q == 3'd7);
    pop           = din_valid && din_ready;
    wr_one        = (ks_count_q == 2'd1) && !pop;
    sr_d          = bit_acc ? {ks_bit, sr_q[7:1]} : sr_q;
    bitcnt_d      = bit_acc ? bitcnt_q + 3'd1 : bitcnt_q;
    // pop shifts the older byte out first; a same-edge push lands behind whatever remains
    fifo0_d       = (push && !wr_one) ? sr_d : pop ? fifo1_q : fifo0_q;
    fifo1_d       = (push && wr_one) ? sr_d : pop ? 8'h00 : fifo1_q;
    ks_count_d    = ks_count_q + {1'b0, push} - {1'b0, pop};
    dout_d        = pop ? din ^ fifo0_q : dout_q;
    dout_valid_d  = pop || (dout_valid_q && !dout_ready);
    byte_cnt_d    = byte_cnt_q + {15'd0, pop};
    ks_overflow_d = ks_overflow_q || (ks_valid && !ks_req);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q          <= '0;
      bitcnt_q      <= '0;
      fifo0_q       <= '0;
      fifo1_q       <= '0;
      ks_count_q    <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      byte_cnt_q    <= '0;
      ks_overflow_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bitcnt_q      <= bitcnt_d;
      fifo0_q       <= fifo0_d;
      fifo1_q       <= fifo1_d;
      ks_count_q    <= ks_count_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      ks_overflow_q <= ks_overflow_d;
    end
  end
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign byte_cnt    = byte_cnt_q;
  assign ks_overflow = ks_overflow_q;
endmodule

// File: doc/keystream_xor.md
KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 The block SHALL have no parameters; the keystream buffer depth is fixed at 2 bytes and the bit order is fixed LSB-first.
REQ-002 clk  input  1  single clock for all state; rising-edge triggered.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ks_bit  input  1  keystream bit from the upstream keystream generator.
REQ-005 ks_valid  input  1  ks_bit is valid this cycle (generator initialized and enabled).
REQ-006 ks_req  output  1  request for keystream bits; drives the generator enable.
REQ-007 din  input  8  plaintext/ciphertext byte in.
REQ-008 din_valid  input  1  din is valid.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 dout  output  8  din XOR keystream byte.
REQ-011 dout_valid  output  1  dout is valid.
REQ-012 dout_ready  input  1  downstream accepts dout.
REQ-013 byte_cnt  output  16  count of bytes transferred on din.
REQ-014 ks_overflow  output  1  sticky flag: a keystream bit arrived while ks_req was low.

Function
REQ-015 Bit packer: 8-bit shift register plus 3-bit counter bitcnt; a bit SHALL be accepted when ks_valid && ks_req.
REQ-016 The first accepted bit of a byte SHALL land in bit 0 and the eighth in bit 7 (LSB-first).
REQ-017 On acceptance of the eighth bit, the completed byte SHALL be pushed into the keystream FIFO on the same edge, and bitcnt SHALL wrap 7->0.
REQ-018 The keystream FIFO SHALL hold 0..2 bytes (ks_count), be first-in first-out, and have its head byte ks_head.
REQ-019 ks_req SHALL equal (ks_count < 2) && !rst, combinationally, from registered ks_count.
REQ-020 ks_valid while ks_req is low SHALL drop the bit, leave the packer unchanged, and set ks_overflow to 1 until reset.
REQ-021 din_ready SHALL equal (ks_count > 0) && (!dout_valid || dout_ready).
REQ-022 A din transfer (din_valid && din_ready) SHALL register dout <= din ^ ks_head and dout_valid <= 1, pop the FIFO, and increment byte_cnt; latency from transfer to dout_valid is 1 cycle.
REQ-023 When dout_valid && dout_ready and no din transfer occurs, dout_valid SHALL clear; dout SHALL hold its value until the next transfer.
REQ-024 When dout_valid && !dout_ready, dout and dout_valid SHALL hold stable.
REQ-025 A simultaneous push and pop SHALL leave ks_count unchanged, and the popped byte SHALL be the older one.
REQ-026 A push is possible only when ks_count < 2, so the FIFO SHALL never overflow; a pop at ks_count == 0 SHALL be impossible by REQ-021.
REQ-027 byte_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-028 A partial byte in the packer SHALL be retained indefinitely while ks_valid is low; no timeout applies.

Reset
REQ-029 While rst is high, all of the following SHALL be forced to 0: shift register, bitcnt, ks_count, FIFO contents, dout, dout_valid, byte_cnt and ks_overflow; ks_req SHALL be 0.
REQ-030 Reset asserted mid-byte or mid-handshake SHALL discard all partial keystream and any pending dout immediately.
REQ-031 After rst deasserts, ks_req SHALL be 1 on the first clock edge and din_ready SHALL be 0 until one full keystream byte is buffered.

Verification
REQ-032 Reset, then bits 1,0,1,1,0,0,0,0 with ks_valid=1, then din=0xA5 -> ks_head=0x0D, next cycle dout=0xA8 with dout_valid=1, and byte_cnt=1.
REQ-033 24 consecutive keystream bits with no din -> ks_req drops after the 16th bit, and ks_valid held for bits 17-24 -> ks_overflow=1 and ks_count stays 2.
REQ-034 2 bytes buffered, din_valid held high, dout_ready=0 -> one transfer occurs, then din_ready=0 and dout is stable; raising dout_ready -> second transfer, output order matches FIFO order.
REQ-035 ks_count=1, eighth bit arrives on the same edge as a din transfer -> ks_count stays 1, and dout uses the old byte.
REQ-036 Preload byte_cnt=0xFFFF through 65535 transfers (or force) -> next transfer gives byte_cnt=0x0000.
REQ-037 rst pulsed after 5 bits and with dout_valid=1 -> all outputs 0 immediately; the next 8 bits form a fresh byte starting at bit 0.
